victim_cache_assoc: RTL and testbench

VICTIM_CACHE_ASSOC -- requirements
Module: victim_cache_assoc

---
 rtl/victim_cache_pkg.sv | 16 +
 rtl/vc_lru.sv | 51 +++++
 rtl/victim_cache_assoc.sv | 172 +++++++++++++++++
 tb/tb_victim_cache_assoc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/victim_cache_pkg.sv
// Shared request-op encoding and default sizing for the victim cache.
package victim_cache_pkg;

   typedef enum logic [1:0] {
      OP_READ   = 2'b00,
      OP_INSERT = 2'b01,
      OP_INVAL  = 2'b10,
      OP_NOP    = 2'b11
   } req_op_e;

   localparam int unsigned VC_ENTRIES     = 8;
   localparam int unsigned VC_TAG_W       = 44;
   localparam int unsigned VC_INDEX_W     = 6;
   localparam int unsigned VC_BLOCK_BYTES = 64;

endpackage

// File: rtl/vc_lru.sv
// True-LRU age tracker: one log2(ENTRIES)-bit age per entry, victim is the oldest entry.
module vc_lru #(
   parameter  int unsigned ENTRIES = 8,
   localparam int unsigned AW      = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ENTRIES-1:0] touch_vec_i,
   input  logic               touch_en_i,
   output logic [AW-1:0]      victim_idx_o
);

   logic [AW-1:0] age_q [ENTRIES];
   logic [AW-1:0] age_d [ENTRIES];
   logic [AW-1:0] old_age;
   logic [AW-1:0] vmax;

   // Ages start out all equal after reset; using <= lets the untouched group
   // age together so a full fill leaves a clean 0..ENTRIES-1 permutation.
   always_comb begin
      old_age = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (touch_vec_i[i]) old_age = old_age | age_q[i];
      for (int i = 0; i < ENTRIES; i++) begin
         age_d[i] = age_q[i];
         if (touch_en_i) begin
            if (touch_vec_i[i])           age_d[i] = '0;
            else if (age_q[i] <= old_age) age_d[i] = age_q[i] + AW'(1);
         end
      end
   end

   always_comb begin
      victim_idx_o = '0;
      vmax         = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (age_q[i] > vmax) begin
            vmax         = age_q[i];
            victim_idx_o = AW'(i);
         end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
      end
   end

endmodule

// File: rtl/victim_cache_assoc.sv
// Fully-associative victim cache, PRE_TL/TL/TV/DM pipeline. All state commits at the
// end of TL, so a request one cycle behind already sees the previous one's update.
module victim_cache_assoc
   import victim_cache_pkg::*;
#(
   parameter  int unsigned ENTRIES     = VC_ENTRIES,
   parameter  int unsigned TAG_W       = VC_TAG_W,
   parameter  int unsigned INDEX_W     = VC_INDEX_W,
   parameter  int unsigned BLOCK_BYTES = VC_BLOCK_BYTES,
   localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES),
   localparam int unsigned BLOCK_W     = 8 * BLOCK_BYTES
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   input  logic [1:0]                  req_op,
   input  logic [INDEX_W+OFFSET_W-1:0] page_offset,
   input  logic [BLOCK_W-1:0]          data_in,
   input  logic [TAG_W-1:0]            phys_tag_ret,
   input  logic                        tlb_miss,
   output logic                        resp_valid,
   output logic                        is_found,
   output logic [7:0]                  byte_out,
   output logic [BLOCK_W-1:0]          block_out,
   output logic                        evict_valid
);

   localparam int unsigned AW = $clog2(ENTRIES);

   // PRE_TL stage registers
   logic                s1_vld_q;
   req_op_e             s1_op_q;
   logic [INDEX_W-1:0]  s1_idx_q;
   logic [OFFSET_W-1:0] s1_off_q;
   logic [BLOCK_W-1:0]  s1_data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= OP_READ;
         s1_idx_q  <= '0;
         s1_off_q  <= '0;
         s1_data_q <= '0;
      end else begin
         s1_vld_q  <= req_valid && (req_op_e'(req_op) != OP_NOP);
         s1_op_q   <= req_op_e'(req_op);
         s1_idx_q  <= page_offset[INDEX_W+OFFSET_W-1:OFFSET_W];
         s1_off_q  <= page_offset[OFFSET_W-1:0];
         s1_data_q <= data_in;
      end
   end

   // Entry storage; only valid bits (and ages) need a reset
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q  [ENTRIES];
   logic [INDEX_W-1:0] eidx_q [ENTRIES];
   logic [BLOCK_W-1:0] data_q [ENTRIES];

   // TL: associative lookup and action decode
   logic [ENTRIES-1:0] hit_vec, touch_vec;
   logic               hit, any_free, rd_hit, do_ins, do_inv, evict, touch_en;
   logic [AW-1:0]      hit_idx, free_idx, victim_idx, ins_idx;
   logic [BLOCK_W-1:0] s2_block_d;

   always_comb begin
      hit_vec  = '0;
      hit_idx  = '0;
      free_idx = '0;
      any_free = 1'b0;
      for (int i = 0; i < ENTRIES; i++)
         hit_vec[i] = valid_q[i] && (tag_q[i] == phys_tag_ret) && (eidx_q[i] == s1_idx_q);
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = AW'(i);
         if (!valid_q[i]) begin
            free_idx = AW'(i);
            any_free = 1'b1;
         end
      end
      hit       = |hit_vec;
      rd_hit    = s1_vld_q && (s1_op_q == OP_READ) && hit && !tlb_miss;
      do_ins    = s1_vld_q && (s1_op_q == OP_INSERT);
      do_inv    = s1_vld_q && (s1_op_q == OP_INVAL) && hit && !tlb_miss;
      evict     = do_ins && !hit && !any_free;
      ins_idx   = hit ? hit_idx : (any_free ? free_idx : victim_idx);
      touch_en  = rd_hit || do_ins;
      touch_vec = ENTRIES'(1) << (do_ins ? ins_idx : hit_idx);
      valid_d   = valid_q;
      if (do_ins) valid_d[ins_idx] = 1'b1;
      if (do_inv) valid_d[hit_idx] = 1'b0;
      s2_block_d = '0;
      if (rd_hit)     s2_block_d = data_q[hit_idx];
      else if (evict) s2_block_d = data_q[victim_idx];
   end

   vc_lru #(.ENTRIES(ENTRIES)) u_lru (
      .clk         (clk),
      .rst_n       (reset),
      .touch_vec_i (touch_vec),
      .touch_en_i  (touch_en),
      .victim_idx_o(victim_idx)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (do_ins) begin
         data_q[ins_idx] <= s1_data_q;
         tag_q[ins_idx]  <= phys_tag_ret;
         eidx_q[ins_idx] <= s1_idx_q;
      end
   end

   // TV stage registers
   logic                s2_vld_q, s2_found_q, s2_evict_q;
   logic [OFFSET_W-1:0] s2_off_q;
   logic [BLOCK_W-1:0]  s2_block_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_vld_q   <= 1'b0;
         s2_found_q <= 1'b0;
         s2_evict_q <= 1'b0;
         s2_off_q   <= '0;
         s2_block_q <= '0;
      end else begin
         s2_vld_q   <= s1_vld_q;
         s2_found_q <= rd_hit;
         s2_evict_q <= evict;
         s2_off_q   <= s1_off_q;
         s2_block_q <= s2_block_d;
      end
   end

   // DM stage registers; the 64-bit word is picked here, the byte after
   logic               resp_valid_q, found_q, evict_q;
   logic [BLOCK_W-1:0] block_q;
   logic [63:0]        word_d, word_q;
   logic [2:0]         bsel_q;

   always_comb begin
      word_d = '0;
      if (s2_found_q) word_d = s2_block_q[64 * (s2_off_q >> 3) +: 64];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_valid_q <= 1'b0;
         found_q      <= 1'b0;
         evict_q      <= 1'b0;
         block_q      <= '0;
         word_q       <= '0;
         bsel_q       <= '0;
      end else begin
         resp_valid_q <= s2_vld_q;
         found_q      <= s2_found_q;
         evict_q      <= s2_evict_q;
         block_q      <= s2_block_q;
         word_q       <= word_d;
         bsel_q       <= s2_off_q[2:0];
      end
   end

   assign resp_valid  = resp_valid_q;
   assign is_found    = found_q;
   assign evict_valid = evict_q;
   assign block_out   = block_q;
   assign byte_out    = word_q[8 * bsel_q +: 8];

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Randomized scoreboard bench for victim_cache_assoc against a slot/recency-list model.
module tb_victim_cache_assoc;
   import victim_cache_pkg::*;

   localparam int E  = 8;
   localparam int TW = 44;
   localparam int IW = 6;
   localparam int OW = 6;
   localparam int BW = 512;

   logic          clk = 1'b0, reset = 1'b0, req_valid = 1'b0, tlb_miss = 1'b0;
   logic [1:0]    req_op = 2'b00;
   logic [IW+OW-1:0] page_offset = '0;
   logic [BW-1:0] data_in = '0;
   logic [TW-1:0] phys_tag_ret = '0;
   logic          resp_valid, is_found, evict_valid;
   logic [7:0]    byte_out;
   logic [BW-1:0] block_out;

   victim_cache_assoc dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .page_offset(page_offset), .data_in(data_in), .phys_tag_ret(phys_tag_ret),
      .tlb_miss(tlb_miss), .resp_valid(resp_valid), .is_found(is_found),
      .byte_out(byte_out), .block_out(block_out), .evict_valid(evict_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          found;
      logic [7:0]    byt;
      logic [BW-1:0] blk;
      logic          ev;
   } exp_t;

   exp_t expq[$];
   exp_t me;
   int   n_cmp = 0, n_bad = 0;

   // reference state: per-slot contents plus a most-recent-first list of slots
   logic          m_vld [E];
   logic [TW-1:0] m_tag [E];
   logic [IW-1:0] m_idx [E];
   logic [BW-1:0] m_dat [E];
   int            rec[$];

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void touch(input int s);
      for (int i = 0; i < rec.size(); i++)
         if (rec[i] == s) begin
            rec.delete(i);
            break;
         end
      rec.push_front(s);
   endfunction

   task automatic model(input logic [1:0] op, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                        input logic [OW-1:0] off, input logic [BW-1:0] dat, input logic tm);
      exp_t e;
      int   hs, fs, s;
      e.found = 1'b0; e.byt = 8'h00; e.blk = '0; e.ev = 1'b0;
      hs = -1; fs = -1;
      for (int i = 0; i < E; i++) begin
         if (m_vld[i] && m_tag[i] == tag && m_idx[i] == idx) hs = i;
         if (!m_vld[i] && fs < 0) fs = i;
      end
      case (op)
         2'b00: if (hs >= 0 && !tm) begin
            e.found = 1'b1;
            e.blk   = m_dat[hs];
            e.byt   = m_dat[hs][int'(off) * 8 +: 8];
            touch(hs);
         end
         2'b01: begin
            if (hs >= 0)      s = hs;
            else if (fs >= 0) s = fs;
            else begin
               s     = rec[rec.size() - 1];
               e.ev  = 1'b1;
               e.blk = m_dat[s];
            end
            m_vld[s] = 1'b1; m_tag[s] = tag; m_idx[s] = idx; m_dat[s] = dat;
            touch(s);
         end
         2'b10: if (hs >= 0 && !tm) m_vld[hs] = 1'b0;
         default: ;
      endcase
      if (op != 2'b11) expq.push_back(e);
   endtask

   // request whose tag/tlb_miss are due in the current cycle
   logic          p_vld = 1'b0, p_tm = 1'b0;
   logic [1:0]    p_op = 2'b00;
   logic [TW-1:0] p_tag = '0;
   logic [IW-1:0] p_idx = '0;
   logic [OW-1:0] p_off = '0;
   logic [BW-1:0] p_dat = '0;

   task automatic step(input logic v, input logic [1:0] op, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                       input logic [OW-1:0] off, input logic [BW-1:0] dat, input logic tm);
      @(negedge clk);
      phys_tag_ret = p_vld ? p_tag : TW'({$urandom, $urandom});
      tlb_miss     = p_vld ? p_tm : 1'($urandom);
      if (p_vld) model(p_op, p_tag, p_idx, p_off, p_dat, p_tm);
      req_valid   = v;
      req_op      = op;
      page_offset = {idx, off};
      data_in     = dat;
      p_vld = v; p_op = op; p_tag = tag; p_idx = idx; p_off = off; p_dat = dat; p_tm = tm;
   endtask

   task automatic rd(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic [OW-1:0] o, input logic tm);
      step(1'b1, 2'b00, t, i, o, BW'($urandom), tm);
   endtask
   task automatic ins(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic [BW-1:0] d);
      step(1'b1, 2'b01, t, i, OW'($urandom), d, 1'($urandom));
   endtask
   task automatic inv(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic tm);
      step(1'b1, 2'b10, t, i, OW'($urandom), '0, tm);
   endtask
   task automatic idle();
      step(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; req_valid = 1'b0; p_vld = 1'b0;
      expq.delete();
      rec.delete();
      for (int i = 0; i < E; i++) m_vld[i] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [BW-1:0] rblk();
      logic [BW-1:0] r;
      for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [TW-1:0] ktag(input int k);
      return TW'(44'h100 + k);
   endfunction

   // monitor: pops one expectation per response, otherwise outputs must be quiet
   initial forever begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
         if (expq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding");
         end else begin
            me = expq.pop_front();
            chk("is_found",    BW'(is_found),    BW'(me.found));
            chk("byte_out",    BW'(byte_out),    BW'(me.byt));
            chk("block_out",   block_out,        me.blk);
            chk("evict_valid", BW'(evict_valid), BW'(me.ev));
         end
      end else begin
         chk("idle_flags", BW'({is_found, evict_valid, byte_out}), '0);
         chk("idle_block", block_out, '0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [BW-1:0] blk;
   int            r;

   initial begin
      for (int i = 0; i < E; i++) m_vld[i] = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_resp_valid", BW'(resp_valid), '0);
      chk("reset_outputs",    BW'({is_found, evict_valid, byte_out}), '0);
      reset = 1'b1;

      rd(44'h1, 6'h05, 6'h00, 1'b0);
      for (int k = 0; k < BW / 8; k++) blk[k*8 +: 8] = 8'(k);
      ins(44'hABC, 6'h12, blk);
      rd(44'hABC, 6'h12, 6'h2A, 1'b0);
      repeat (4) idle();

      do_reset();
      for (int k = 0; k < 8; k++) ins(ktag(k), 6'h03, rblk());
      rd(ktag(0), 6'h03, OW'($urandom), 1'b0);
      ins(ktag(8), 6'h03, rblk());
      rd(ktag(1), 6'h03, OW'($urandom), 1'b0);
      rd(ktag(0), 6'h03, OW'($urandom), 1'b0);
      rd(ktag(2), 6'h03, OW'($urandom), 1'b1);
      inv(ktag(3), 6'h03, 1'b0);
      rd(ktag(3), 6'h03, OW'($urandom), 1'b0);
      ins(ktag(9), 6'h03, rblk());
      rd(ktag(9), 6'h03, OW'($urandom), 1'b0);
      ins(ktag(10), 6'h03, rblk());
      ins(ktag(11), 6'h03, rblk());
      step(1'b1, 2'b11, ktag(4), 6'h03, 6'h00, rblk(), 1'b0);
      rd(ktag(4), 6'h03, OW'($urandom), 1'b0);
      repeat (4) idle();

      rd(ktag(4), 6'h03, 6'h10, 1'b0);
      idle();
      do_reset();
      rd(ktag(4), 6'h03, 6'h10, 1'b0);
      repeat (4) idle();

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) do_reset();
         r = $urandom_range(0, 99);
         if (r < 40)      rd(TW'(44'h200 + $urandom_range(0, 15)), IW'($urandom_range(0, 1)), OW'($urandom), $urandom_range(0, 4) == 0);
         else if (r < 75) ins(TW'(44'h200 + $urandom_range(0, 15)), IW'($urandom_range(0, 1)), rblk());
         else if (r < 85) inv(TW'(44'h200 + $urandom_range(0, 15)), IW'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
         else if (r < 92) step(1'b1, 2'b11, TW'($urandom), IW'($urandom), OW'($urandom), rblk(), 1'b0);
         else             idle();
      end
      repeat (6) idle();
      chk("drain_outstanding", BW'(expq.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
